// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes and hex decoder for the scanned 7-segment driver
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_L   = 7'h38;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_R   = 7'h50;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Nibbles C and F map to the calculator's L and r glyphs.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_L;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_R;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// rtl/seg7_scan_timer.sv - slot prescaler, digit index, frame pulse and blink phase
module seg7_scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          slot_start,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          frame_done,
  output logic                          blink_phase
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          term;

  assign term       = (presc == PW'(CLK_DIV - 1));
  assign slot_start = (presc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      frame_done  <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      presc      <= term ? '0 : presc + 1'b1;
      frame_done <= 1'b0;
      if (term) begin
        if (idx == IW'(NUM_DIGITS - 1)) begin
          idx        <= '0;
          frame_done <= 1'b1;
          // Blink counts whole frames so the phase only flips between frames.
          if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit 7-segment driver with blanking and blink
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank_en,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int                    IW      = $clog2(NUM_DIGITS);
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    loaded;

  logic          slot_start;
  logic [IW-1:0] idx;
  logic          blink_phase;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .CLK_DIV     (CLK_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_start (slot_start),
    .idx        (idx),
    .frame_done (frame_done),
    .blink_phase(blink_phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
      loaded    <= 1'b0;
    end else if (load) begin
      sh_digits <= digits_in;
      sh_dp     <= dp_in;
      sh_blank  <= blank_in;
      loaded    <= 1'b1;
    end
  end

  // lz_zero[k] is set when every nibble from the top down to k is zero.
  logic [NUM_DIGITS-1:0] lz_zero;
  logic                  zero_above;
  always_comb begin
    lz_zero    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (sh_digits[4*k +: 4] == 4'h0);
      lz_zero[k] = zero_above;
    end
  end

  logic [3:0]            cur_nib;
  logic                  dark;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  assign cur_nib = sh_digits[{idx, 2'b00} +: 4];
  assign dark    = slot_start | sh_blank[idx] | (lz_blank_en & lz_zero[idx])
                 | (blink_en & ~blink_phase);
  // Anodes stay fully off until something has been loaded.
  assign an_hi   = (slot_start | ~loaded) ? '0 : (NUM_DIGITS'(1) << idx);
  assign seg_hi  = dark ? SEG_OFF : hex_to_seg(cur_nib);
  assign dp_hi   = ~dark & sh_dp[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_INV;
      dp  <= DP_INV;
      an  <= AN_INV;
    end else begin
      seg <= seg_hi ^ SEG_INV;
      dp  <= dp_hi ^ DP_INV;
      an  <= an_hi ^ AN_INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_blank_en = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_blank_en(lz_blank_en), .blink_en(blink_en),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    @(negedge clk);
    digits_in = d; dp_in = p; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic sync_frame();
    logic found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    check("sync_frame", found, 1);
  endtask

  // segs holds active-high codes {d3,d2,d1,d0}; lit marks digits expected visible.
  task automatic check_frame(input string tag, input logic [27:0] segs,
                             input logic [3:0] dps, input logic [3:0] lit);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, "_gap_an"}, an, 4'hF);
      check({tag, "_gap_seg"}, seg, 7'h7F);
      ea = ~(4'b0001 << k);
      es = lit[k] ? ~segs[k*7 +: 7] : 7'h7F;
      ed = ~(lit[k] & dps[k]);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check({tag, "_an"}, an, ea);
        check({tag, "_seg"}, seg, es);
        check({tag, "_dp"}, dp, ed);
      end
    end
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] lit;

    // Reset state, then stays dark without a load
    @(negedge clk);
    @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an !== 4'hF || seg !== 7'h7F) bad++;
    end
    check("dark_before_load", bad, 0);

    // Basic scan with a decimal point
    do_load(16'h1234, 4'b0100, 4'b0000);
    check_frame("d1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'b1111);

    // Leading-zero suppression
    lz_blank_en = 1'b1;
    do_load(16'h0070, 4'b0000, 4'b0000);
    check_frame("lz0070", {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000, 4'b0011);
    do_load(16'h0000, 4'b0000, 4'b0000);
    check_frame("lz0000", {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 4'b0001);
    lz_blank_en = 1'b0;

    // Letter glyphs, then per-digit blank overriding dp
    do_load(16'hFEDC, 4'b0000, 4'b0000);
    check_frame("fedc", {7'h50, 7'h79, 7'h5E, 7'h38}, 4'b0000, 4'b1111);
    do_load(16'hFEDC, 4'b0010, 4'b0010);
    check_frame("blank1", {7'h50, 7'h79, 7'h5E, 7'h38}, 4'b0010, 4'b1101);

    // Frame period
    sync_frame();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (frame_done) break;
    end
    check("frame_period", n, 16);
    repeat (15) @(negedge clk);
    // Load arriving on the wrap edge
    digits_in = 16'h5555; dp_in = 4'b0000; blank_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("wrap_fd", frame_done, 1);
    @(negedge clk);
    check("wrap_fd_width", frame_done, 0);
    check("wrap_gap_an", an, 4'hF);
    @(negedge clk);
    check("wrap_an", an, 4'hE);
    check("wrap_seg", seg, 7'h12);

    // Blink: two frames lit, two dark, anodes still scanning
    blink_en = 1'b1;
    lit = '0;
    for (int i = 0; i < 8; i++) begin
      sync_frame();
      @(negedge clk);
      @(negedge clk);
      check("blink_an", an, 4'hE);
      lit[i] = (seg != 7'h7F);
    end
    check("blink_lit_count", $countones(lit), 4);
    for (int i = 0; i < 6; i++) check("blink_alt", lit[i] ^ lit[i+2], 1);
    blink_en = 1'b0;

    // Asynchronous reset mid-slot
    sync_frame();
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_an", an, 4'hE);
    #3 rst_n = 1'b0;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_dp", dp, 1);
    check("arst_fd", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("restart_gap", an, 4'hF);
    @(negedge clk);
    check("restart_an", an, 4'hE);
    check("restart_seg", seg, 7'h19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
